// File: rtl/mips_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_cpu_bus_arbiter
//   Two-master / one-slave arbiter for the CPU's Avalon-style memory bus.
//   Master 0 is the instruction-fetch port, master 1 the load/store port; the
//   slave side drives the single RAM instance. Ownership is registered and held
//   until the slave completes the transfer. A sticky bus_error flag reports a
//   granted transfer that stays stalled for MAX_WAIT consecutive cycles.
//
// Parameters
//   ARB_MODE : 0 = round-robin on ties, 1 = fixed priority (m0 wins ties)
//   MAX_WAIT : stalled granted cycles before bus_error sets (0 = disabled)
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   m0_* / m1_*                : master address/read/write/writedata/
//                                byteenable in, readdata/waitrequest out
//   s_*                        : slave address/read/write/writedata/
//                                byteenable out, readdata/waitrequest in
//   grant                      : one-hot owner (01 = m0, 10 = m1, 00 = idle)
//   bus_error                  : sticky timeout flag
// -----------------------------------------------------------------------------
module mips_cpu_bus_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int MAX_WAIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,
  output logic [1:0]  grant,
  output logic        bus_error
);

  localparam int               CNT_W      = (MAX_WAIT > 32'sd0) ? $clog2(MAX_WAIT + 32'sd1) : 32'sd1;
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'sd1);
  localparam bit               TIMEOUT_EN = (MAX_WAIT > 32'sd0);
  localparam bit               FIXED_PRIO = (ARB_MODE == 32'sd1);
  localparam logic             LAST_M0    = 1'b0;
  localparam logic             LAST_M1    = 1'b1;

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             bus_error_r;
  logic             req0_s;
  logic             req1_s;
  logic             done0_s;
  logic             done1_s;
  logic             stall_s;
  logic             timeout_hit_s;

  assign req0_s    = m0_read | m0_write;
  assign req1_s    = m1_read | m1_write;
  assign grant     = state_r;
  assign bus_error = bus_error_r;

  // Next-state selection, slave-side mux and master-side responses.
  always_comb begin
    state_nxt_s    = state_r;
    s_address      = 32'h0000_0000;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = 32'h0000_0000;
    s_byteenable   = 4'b0000;
    m0_readdata    = 32'h0000_0000;
    m1_readdata    = 32'h0000_0000;
    m0_waitrequest = req0_s;
    m1_waitrequest = req1_s;
    done0_s        = 1'b0;
    done1_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0_s && req1_s) begin
          // Round-robin hands the tie to whoever was not served last.
          if (FIXED_PRIO || (last_r == LAST_M1)) begin
            state_nxt_s = ST_GNT0;
          end else begin
            state_nxt_s = ST_GNT1;
          end
        end else if (req0_s) begin
          state_nxt_s = ST_GNT0;
        end else if (req1_s) begin
          state_nxt_s = ST_GNT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GNT0: begin
        s_address    = m0_address;
        s_read       = m0_read;
        s_write      = m0_write;
        s_writedata  = m0_writedata;
        s_byteenable = m0_byteenable;
        m0_readdata  = s_readdata;
        if (!req0_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!s_waitrequest) begin
          done0_s        = 1'b1;
          m0_waitrequest = 1'b0;
          // Hand straight over to a waiting m1 so there is no idle bubble.
          state_nxt_s    = req1_s ? ST_GNT1 : ST_IDLE;
        end else begin
          state_nxt_s = ST_GNT0;
        end
      end
      ST_GNT1: begin
        s_address    = m1_address;
        s_read       = m1_read;
        s_write      = m1_write;
        s_writedata  = m1_writedata;
        s_byteenable = m1_byteenable;
        m1_readdata  = s_readdata;
        if (!req1_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!s_waitrequest) begin
          done1_s        = 1'b1;
          m1_waitrequest = 1'b0;
          state_nxt_s    = req0_s ? ST_GNT0 : ST_IDLE;
        end else begin
          state_nxt_s = ST_GNT1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Stall counter next value; saturates at MAX_CNT instead of wrapping.
  always_comb begin
    stall_s       = (((state_r == ST_GNT0) && req0_s) ||
                     ((state_r == ST_GNT1) && req1_s)) && s_waitrequest;
    cnt_nxt_s     = {CNT_W{1'b0}};
    timeout_hit_s = 1'b0;
    if (stall_s) begin
      if (cnt_r != MAX_CNT) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
      timeout_hit_s = TIMEOUT_EN && (cnt_nxt_s == MAX_CNT);
    end else begin
      cnt_nxt_s     = {CNT_W{1'b0}};
      timeout_hit_s = 1'b0;
    end
  end

  // State, last-served, stall counter and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      last_r      <= LAST_M1;
      cnt_r       <= {CNT_W{1'b0}};
      bus_error_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      // An aborted (dropped) request leaves last_r untouched.
      if (done0_s) begin
        last_r <= LAST_M0;
      end else if (done1_s) begin
        last_r <= LAST_M1;
      end else begin
        last_r <= last_r;
      end
      if (timeout_hit_s) begin
        bus_error_r <= 1'b1;
      end else begin
        bus_error_r <= bus_error_r;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_cpu_bus_arbiter
//   Two arbiter instances side by side: index 0 is round-robin with MAX_WAIT=4,
//   index 1 is fixed priority with the timeout disabled. Each has its own
//   reset, masters and slave. Stimulus pushes expected completions into a
//   per-instance queue; a negedge monitor pops and compares on every
//   completed transfer. Directed checks cover latency, stalls, timeout and
//   asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mips_cpu_bus_arbiter;

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  rw;     // {s_read, s_write}
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] rd;
  } xfer_t;

  logic        clk;
  logic        rst     [2];
  logic [31:0] m_addr  [2][2];
  logic        m_rd    [2][2];
  logic        m_wr    [2][2];
  logic [31:0] m_wd    [2][2];
  logic [3:0]  m_be    [2][2];
  logic [31:0] m_rdata [2][2];
  logic        m_wait  [2][2];
  logic [31:0] s_addr  [2];
  logic        s_rd    [2];
  logic        s_wr    [2];
  logic [31:0] s_wd    [2];
  logic [3:0]  s_be    [2];
  logic [31:0] s_rdata [2];
  logic        s_wait  [2];
  logic [1:0]  gnt     [2];
  logic        berr    [2];

  int    errors = 0;
  int    checks = 0;
  xfer_t q0[$];
  xfer_t q1[$];

  // Simple RAM read model: two known fetch words, otherwise a scramble.
  function automatic logic [31:0] ram_model(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h3C03_BFC0;
      32'hBFC0_0004: return 32'h8C43_0000;
      default:       return a ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign s_rdata[0] = ram_model(s_addr[0]);
  assign s_rdata[1] = ram_model(s_addr[1]);

  mips_cpu_bus_arbiter #(.ARB_MODE(0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .reset(rst[0]),
    .m0_address(m_addr[0][0]), .m0_read(m_rd[0][0]), .m0_write(m_wr[0][0]),
    .m0_writedata(m_wd[0][0]), .m0_byteenable(m_be[0][0]),
    .m0_readdata(m_rdata[0][0]), .m0_waitrequest(m_wait[0][0]),
    .m1_address(m_addr[0][1]), .m1_read(m_rd[0][1]), .m1_write(m_wr[0][1]),
    .m1_writedata(m_wd[0][1]), .m1_byteenable(m_be[0][1]),
    .m1_readdata(m_rdata[0][1]), .m1_waitrequest(m_wait[0][1]),
    .s_address(s_addr[0]), .s_read(s_rd[0]), .s_write(s_wr[0]),
    .s_writedata(s_wd[0]), .s_byteenable(s_be[0]),
    .s_readdata(s_rdata[0]), .s_waitrequest(s_wait[0]),
    .grant(gnt[0]), .bus_error(berr[0])
  );

  mips_cpu_bus_arbiter #(.ARB_MODE(1), .MAX_WAIT(0)) dut_fp (
    .clk(clk), .reset(rst[1]),
    .m0_address(m_addr[1][0]), .m0_read(m_rd[1][0]), .m0_write(m_wr[1][0]),
    .m0_writedata(m_wd[1][0]), .m0_byteenable(m_be[1][0]),
    .m0_readdata(m_rdata[1][0]), .m0_waitrequest(m_wait[1][0]),
    .m1_address(m_addr[1][1]), .m1_read(m_rd[1][1]), .m1_write(m_wr[1][1]),
    .m1_writedata(m_wd[1][1]), .m1_byteenable(m_be[1][1]),
    .m1_readdata(m_rdata[1][1]), .m1_waitrequest(m_wait[1][1]),
    .s_address(s_addr[1]), .s_read(s_rd[1]), .s_write(s_wr[1]),
    .s_writedata(s_wd[1]), .s_byteenable(s_be[1]),
    .s_readdata(s_rdata[1]), .s_waitrequest(s_wait[1]),
    .grant(gnt[1]), .bus_error(berr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic xfer_t mk(input int k, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be,
                               input logic [31:0] rd);
    xfer_t x;
    x.gnt  = (k == 0) ? 2'b01 : 2'b10;
    x.rw   = wr ? 2'b01 : 2'b10;
    x.addr = a;
    x.wd   = wd;
    x.be   = be;
    x.rd   = wr ? 32'h0 : rd;
    return x;
  endfunction

  task automatic push(input int d, input xfer_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drv(input int d, input int k, input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    m_rd[d][k]   = rd;
    m_wr[d][k]   = wr;
    m_addr[d][k] = a;
    m_wd[d][k]   = wd;
    m_be[d][k]   = be;
  endtask

  task automatic rd_req(input int d, input int k, input logic [31:0] a);
    drv(d, k, 1'b1, 1'b0, a, 32'h0, 4'hF);
  endtask

  task automatic idle_m(input int d, input int k);
    drv(d, k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Wait (bounded) for master k to see waitrequest low, then drop its request.
  task automatic xfer_done(input int d, input int k, output int n);
    logic done;
    done = 1'b0;
    n    = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (!m_wait[d][k]) done = 1'b1;
    end
    chk($sformatf("d%0d m%0d completes within bound", d, k), done, 1'b1);
    @(posedge clk); #1;
    idle_m(d, k);
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    idle_m(d, 0);
    idle_m(d, 1);
    s_wait[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst[d] = 1'b0;
  endtask

  // Monitor: every completed transfer must match the next queued expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        if (!rst[d] && (m_rd[d][k] || m_wr[d][k]) && !m_wait[d][k]) begin
          xfer_t obs;
          xfer_t e;
          int    sz;
          obs.gnt  = gnt[d];
          obs.rw   = {s_rd[d], s_wr[d]};
          obs.addr = s_addr[d];
          obs.wd   = s_wd[d];
          obs.be   = s_be[d];
          obs.rd   = s_wr[d] ? 32'h0 : m_rdata[d][k];
          sz = (d == 0) ? q0.size() : q1.size();
          chk($sformatf("d%0d m%0d completion expected", d, k), (sz != 0), 1'b1);
          if (sz != 0) begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("d%0d m%0d transfer", d, k), obs, e);
          end
        end
      end
    end
  end

  task automatic run_all(input int d);
    int n0;
    int n1;
    int r;
    // Reset values, with m0 already requesting during reset.
    rst[d] = 1'b1;
    s_wait[d] = 1'b0;
    idle_m(d, 1);
    rd_req(d, 0, 32'hBFC0_0000);
    @(posedge clk); #1;
    chk($sformatf("d%0d reset grant/err/strobes", d),
        {gnt[d], berr[d], s_rd[d], s_wr[d], m_wait[d][0]}, {2'b00, 1'b0, 1'b0, 1'b0, 1'b1});
    do_reset(d);

    // Single fetch with a zero-wait RAM.
    push(d, mk(0, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 32'h3C03_BFC0));
    rd_req(d, 0, 32'hBFC0_0000);
    @(negedge clk);
    chk($sformatf("d%0d fetch request cycle", d), {s_rd[d], m_wait[d][0], gnt[d]}, {1'b0, 1'b1, 2'b00});
    @(negedge clk);
    chk($sformatf("d%0d fetch slave cycle", d),
        {s_rd[d], m_wait[d][0], gnt[d], m_rdata[d][0]}, {1'b1, 1'b0, 2'b01, 32'h3C03_BFC0});
    @(posedge clk); #1;
    idle_m(d, 0);
    @(negedge clk);
    chk($sformatf("d%0d fetch back to idle", d), gnt[d], 2'b00);

    // Simultaneous requests after reset: m0 first, m1 with no idle gap.
    do_reset(d);
    push(d, mk(0, 1'b0, 32'hBFC0_0004, 32'h0, 4'hF, 32'h8C43_0000));
    push(d, mk(1, 1'b1, 32'h0000_1000, 32'h0000_0221, 4'hF, 32'h0));
    rd_req(d, 0, 32'hBFC0_0004);
    drv(d, 1, 1'b0, 1'b1, 32'h0000_1000, 32'h0000_0221, 4'hF);
    fork
      xfer_done(d, 0, n0);
      xfer_done(d, 1, n1);
    join
    chk($sformatf("d%0d tie m0 cycles", d), n0, 2);
    chk($sformatf("d%0d tie m1 cycles (no gap)", d), n1, 3);

    // Continuous requests from both masters: grants alternate.
    do_reset(d);
    for (int i = 0; i < 3; i++) begin
      push(d, mk(0, 1'b0, 32'hBFC0_0100 + 32'(i * 4), 32'h0, 4'hF, ram_model(32'hBFC0_0100 + 32'(i * 4))));
      push(d, mk(1, 1'b1, 32'h0000_1100 + 32'(i * 4), 32'h0000_0A00 + 32'(i), 4'hF, 32'h0));
    end
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          rd_req(d, 0, 32'hBFC0_0100 + 32'(i * 4));
          xfer_done(d, 0, n);
          chk($sformatf("d%0d fair m0 #%0d cycles", d, i), n, 2);
        end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          int n;
          drv(d, 1, 1'b0, 1'b1, 32'h0000_1100 + 32'(i * 4), 32'h0000_0A00 + 32'(i), 4'hF);
          xfer_done(d, 1, n);
          chk($sformatf("d%0d fair m1 #%0d cycles", d, i), n, (i == 0) ? 3 : 2);
        end
      end
    join

    // Tie from idle after m0 was served last: the modes differ here.
    do_reset(d);
    push(d, mk(0, 1'b0, 32'hBFC0_0010, 32'h0, 4'hF, ram_model(32'hBFC0_0010)));
    rd_req(d, 0, 32'hBFC0_0010);
    xfer_done(d, 0, n0);
    if (d == 0) begin
      push(d, mk(1, 1'b1, 32'h0000_1200, 32'h1234_5678, 4'hF, 32'h0));
      push(d, mk(0, 1'b0, 32'hBFC0_0014, 32'h0, 4'hF, ram_model(32'hBFC0_0014)));
    end else begin
      push(d, mk(0, 1'b0, 32'hBFC0_0014, 32'h0, 4'hF, ram_model(32'hBFC0_0014)));
      push(d, mk(1, 1'b1, 32'h0000_1200, 32'h1234_5678, 4'hF, 32'h0));
    end
    rd_req(d, 0, 32'hBFC0_0014);
    drv(d, 1, 1'b0, 1'b1, 32'h0000_1200, 32'h1234_5678, 4'hF);
    fork
      xfer_done(d, 0, n0);
      xfer_done(d, 1, n1);
    join
    chk($sformatf("d%0d second tie m0 cycles", d), n0, (d == 0) ? 3 : 2);
    chk($sformatf("d%0d second tie m1 cycles", d), n1, (d == 0) ? 2 : 3);

    // m1 arrives one cycle after m0: m0 already owns the bus.
    do_reset(d);
    push(d, mk(0, 1'b0, 32'hBFC0_0018, 32'h0, 4'hF, ram_model(32'hBFC0_0018)));
    push(d, mk(1, 1'b1, 32'h0000_1004, 32'h0000_00FF, 4'hF, 32'h0));
    rd_req(d, 0, 32'hBFC0_0018);
    @(posedge clk); #1;
    drv(d, 1, 1'b0, 1'b1, 32'h0000_1004, 32'h0000_00FF, 4'hF);
    fork
      xfer_done(d, 0, n0);
      xfer_done(d, 1, n1);
    join
    chk($sformatf("d%0d late m1: m0 cycles", d), n0, 1);
    chk($sformatf("d%0d late m1: m1 cycles", d), n1, 2);

    // Slave stall of 3 cycles on an m1 write; m0 waits behind it.
    do_reset(d);
    push(d, mk(1, 1'b1, 32'h0000_2000, 32'hCAFE_0011, 4'b0011, 32'h0));
    push(d, mk(0, 1'b0, 32'hBFC0_0008, 32'h0, 4'hF, ram_model(32'hBFC0_0008)));
    s_wait[d] = 1'b1;
    drv(d, 1, 1'b0, 1'b1, 32'h0000_2000, 32'hCAFE_0011, 4'b0011);
    @(negedge clk);
    @(posedge clk); #1;
    rd_req(d, 0, 32'hBFC0_0008);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("d%0d stall cycle %0d", d, i),
          {s_wr[d], s_rd[d], s_addr[d], s_wd[d], s_be[d], m_wait[d][1], m_wait[d][0], gnt[d], m_rdata[d][0]},
          {1'b1, 1'b0, 32'h0000_2000, 32'hCAFE_0011, 4'b0011, 1'b1, 1'b1, 2'b10, 32'h0});
    end
    @(posedge clk); #1;
    s_wait[d] = 1'b0;
    xfer_done(d, 1, n1);
    xfer_done(d, 0, n0);
    chk($sformatf("d%0d stall release cycles", d), {n1[7:0], n0[7:0]}, {8'd1, 8'd1});
    chk($sformatf("d%0d no error after 3 stalls", d), berr[d], 1'b0);

    // Permanent stall: bus_error after 4 stalled grant cycles (instance 0 only).
    do_reset(d);
    push(d, mk(1, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 32'h0));
    s_wait[d] = 1'b1;
    drv(d, 1, 1'b0, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk);
      if (i == 5) chk($sformatf("d%0d error clear before limit", d), berr[d], 1'b0);
      if (i == 6) chk($sformatf("d%0d error at limit", d), berr[d], (d == 0));
      if (i == 7) chk($sformatf("d%0d transfer not aborted", d), {gnt[d], s_wr[d]}, {2'b10, 1'b1});
    end
    @(posedge clk); #1;
    s_wait[d] = 1'b0;
    xfer_done(d, 1, n1);
    @(negedge clk);
    chk($sformatf("d%0d error sticky after release", d), berr[d], (d == 0));

    // Reset asserted mid-transfer during GNT1.
    do_reset(d);
    s_wait[d] = 1'b1;
    drv(d, 1, 1'b0, 1'b1, 32'h0000_4000, 32'h1122_3344, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("d%0d pre-reset write active", d), {s_wr[d], gnt[d]}, {1'b1, 2'b10});
    #1 rst[d] = 1'b1;
    #1;
    chk($sformatf("d%0d async reset outputs", d),
        {s_wr[d], s_rd[d], gnt[d], m_wait[d][1], berr[d]}, {1'b0, 1'b0, 2'b00, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk($sformatf("d%0d strobes low while in reset", d), {s_wr[d], gnt[d]}, {1'b0, 2'b00});
    idle_m(d, 1);
    s_wait[d] = 1'b0;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    push(d, mk(0, 1'b0, 32'hBFC0_001C, 32'h0, 4'hF, ram_model(32'hBFC0_001C)));
    push(d, mk(1, 1'b1, 32'h0000_1008, 32'h0000_0055, 4'hF, 32'h0));
    rd_req(d, 0, 32'hBFC0_001C);
    drv(d, 1, 1'b0, 1'b1, 32'h0000_1008, 32'h0000_0055, 4'hF);
    fork
      xfer_done(d, 0, n0);
      xfer_done(d, 1, n1);
    join
    chk($sformatf("d%0d post-reset tie to m0", d), {n0[7:0], n1[7:0]}, {8'd2, 8'd3});

    repeat (2) @(posedge clk);
    r = (d == 0) ? q0.size() : q1.size();
    chk($sformatf("d%0d all expectations consumed", d), r, 0);
  endtask

  initial begin
    fork
      run_all(0);
      run_all(1);
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at time limit, required completion");
    $fatal(1, "time limit");
  end

endmodule
